// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock with a single borrow FF.
// Latency: start accepted at edge E0, result registered at edge E_WIDTH, valid high for the following cycle.
// Backpressure: ready is high only in IDLE; start while busy is dropped, not queued.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, accepted on an edge where ready=1
//   a, b, bin         minuend, subtrahend, borrow-in; sampled at accept
//   ready, valid      idle indicator / one-cycle result strobe
//   diff              registered WIDTH-bit difference
//   borrow, zero      unsigned borrow-out, diff==0
//   overflow          two's-complement overflow of a - b - bin
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ready;
  logic             w_valid;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_bff;
  logic [CW-1:0]    r_cnt;
  // Operand sign bits are kept aside because the shift registers lose them.
  logic             r_a_msb;
  logic             r_b_msb;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;
  logic             r_overflow;

  logic             w_x;
  logic             w_y;
  logic             w_c;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_nxt;

  // Full-subtractor cell on the current LSB pair.
  assign w_x       = r_a_sr[0];
  assign w_y       = r_b_sr[0];
  assign w_c       = r_bff;
  assign w_d       = w_x ^ w_y ^ w_c;
  assign w_bout    = (~w_x & w_y) | (~(w_x ^ w_y) & w_c);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  assign w_last    = (r_cnt == LAST_BIT);
  assign w_accept  = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand load, serial shift, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res      <= '0;
      r_bff      <= 1'b0;
      r_cnt      <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_res   <= '0;
      r_bff   <= bin;
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == S_SHIFT) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_res  <= w_res_nxt;
      r_bff  <= w_bout;
      r_cnt  <= r_cnt + CW'(1);
      // Result and flags are published only on the final bit so they stay
      // stable for the whole operation.
      if (w_last) begin
        r_diff     <= w_res_nxt;
        r_borrow   <= w_bout;
        r_zero     <= (w_res_nxt == '0);
        r_overflow <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign ready    = w_ready;
  assign valid    = w_valid;
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign zero     = r_zero;
  assign overflow = r_overflow;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor for the ALU: computes a - b - bin, one bit per clock, LSB first.
- Uses a single borrow flip-flop, the subtraction counterpart of the full-adder cell.
- Start/ready/valid handshake with registered result and flags.
- Intended as a low-area arithmetic unit and a building block for later sequential divide/compare logic.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on a clk edge where ready=1
- a  input  WIDTH  minuend; sampled at accept
- b  input  WIDTH  subtrahend; sampled at accept
- bin  input  1  borrow-in; sampled at accept
- ready  output  1  high only in IDLE
- valid  output  1  one-cycle pulse marking a new result
- diff  output  WIDTH  registered difference
- borrow  output  1  unsigned borrow-out; 1 iff a < b + bin
- zero  output  1  1 iff diff == 0
- overflow  output  1  signed (two's complement) overflow of a - b - bin

Behaviour:
- Reset: rst high at an edge forces state=IDLE, bit counter=0, borrow FF=0, ready=1, valid=0, diff=0, borrow=0, zero=0, overflow=0.
- rst has priority over every other input, including mid-operation; the in-flight operation is discarded with no valid pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge:
  - load a and b into shift registers, bin into the borrow FF, counter=0; go to SHIFT.
  - Output registers keep their previous values.
- IDLE, start=0: stay in IDLE.
- SHIFT, each edge, with x = a_sr[0], y = b_sr[0], c = borrow FF:
  - d = x^y^c
  - bout = (~x&y) | (~(x^y)&c)
  - shift d into the MSB of the result register; shift a_sr and b_sr right by 1; borrow FF=bout; counter+1.
  - After the edge processing bit WIDTH-1, go to DONE.
- Entering DONE updates, at that same edge:
  - diff = full result
  - borrow = final bout
  - zero = (diff == 0)
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the sampled operands.
- DONE: valid=1, ready=0 for exactly one cycle; next edge goes to IDLE.
- Latency: start accepted at edge E0 -> valid high in the cycle after edge E_WIDTH (WIDTH+1 cycles from request to result); ready returns high after edge E_(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles with start held high.
- start while ready=0 (SHIFT or DONE) is ignored; it is not queued.
- a, b and bin may change freely after accept without affecting the result.
- diff and all flags hold their values until the next completion or reset; they do not change during SHIFT.
- Width rules:
  - result is WIDTH bits, modulo 2^WIDTH
  - borrow is the (WIDTH+1)-th bit of the unsigned subtraction
  - bin=1 with a=b gives all-ones, borrow=1
- Counter width is clog2(WIDTH)+1; no wrap occurs within an operation.

Test Plan (WIDTH=8):
- Reset, then 8'd5 - 8'd3, bin=0:
  - ready=1, valid=0 and all outputs 0 after reset.
  - valid pulses exactly once, 9 cycles after the accept edge.
  - diff=8'h02, borrow=0, zero=0, overflow=0.
- 8'd3 - 8'd5, bin=0 -> diff=8'hFE, borrow=1, zero=0, overflow=0.
- 8'h80 - 8'h01 -> diff=8'h7F, borrow=0, overflow=1.
- Equal and borrow-in cases:
  - 8'h10 - 8'h10, bin=0 -> diff=8'h00, zero=1, borrow=0.
  - 8'h00 - 8'h00, bin=1 -> diff=8'hFF, borrow=1, zero=0, overflow=0.
- Start 8'h7F - 8'hFF (expected diff=8'h80, borrow=1, overflow=1), then during SHIFT:
  - pulse start with different operands and change a/b: the result is unaffected and only one valid pulse occurs.
  - back-to-back start held high: the second accept occurs the cycle after valid.
- Assert rst on the 4th SHIFT cycle of 8'hAA - 8'h55:
  - no valid pulse; outputs return to reset values.
  - ready=1 the next cycle.
  - a subsequent 8'h09 - 8'h04 gives diff=8'h05 correctly (no stale borrow).
